// File: rtl/pipelined_control_decoder.sv
// Purpose : RV32I(+M) decode stage; registers datapath controls for the execute stage (ID/EX register).
// Latency : 1 cycle from accept to out_valid; MUL/DIV wait for md_done before out_valid is raised.
// Backpres: in_ready drops while the held result is not taken, during an M-ext wait and while flush is high.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          fetch handshake carrying in_instr / in_pc
//   flush                      kills the held and any incoming instruction
//   out_valid/out_ready        execute handshake; all out_* and control fields are held until taken
//   md_start/md_abort/md_op    one-cycle pulses and op code for the external multiply/divide unit
//   md_done                    multiply/divide unit finished
//   illegal_count              saturating count of illegal instructions handed to execute
module pipelined_control_decoder #(
    parameter int HAS_M = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_func_3,
    output logic             write,
    output logic             store,
    output logic             load,
    output logic             branch,
    output logic [1:0]       alu_operand_a_selector,
    output logic [1:0]       alu_operand_b_selector,
    output logic [2:0]       immediate_selector,
    output logic [1:0]       next_pc_selector,
    output logic [3:0]       alu_operations_selector,
    output logic             out_illegal,
    output logic             md_start,
    output logic             md_abort,
    output logic [2:0]       md_op,
    input  logic             md_done,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic       write;
        logic       store;
        logic       load;
        logic       branch;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [2:0] imm_sel;
        logic [1:0] npc_sel;
        logic [3:0] alu_op;
        logic       illegal;
    } ctl_t;

    state_t           state_q;
    logic             out_valid_q;
    ctl_t             ctl_q;
    ctl_t             ctl_d;
    logic             is_md_d;
    logic [31:0]      pc_q;
    logic [4:0]       rd_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [2:0]       f3_q;
    logic             md_start_q;
    logic             md_abort_q;
    logic [2:0]       md_op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    assign in_ready = rst_n && !flush && (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Combinational decode of the incoming word; captured into ctl_q on accept.
    always_comb begin
        logic bad;
        ctl_d   = '0;
        is_md_d = 1'b0;
        bad     = 1'b0;
        case (opcode)
            7'b0110011: begin
                ctl_d.write = 1'b1;
                if (f7 == 7'b0000000) begin
                    ctl_d.alu_op = {1'b0, f3};
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    ctl_d.alu_op = {1'b1, f3};
                end else if (f7 == 7'b0000001 && HAS_M != 0) begin
                    is_md_d = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            7'b0010011: begin
                ctl_d.write = 1'b1;
                ctl_d.b_sel = 2'b01;
                // Only the shift-immediates constrain func_7; bit 5 selects SRAI.
                if (f3 == 3'b001) begin
                    bad = (f7 != 7'b0000000);
                    ctl_d.alu_op = 4'b0001;
                end else if (f3 == 3'b101) begin
                    bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    ctl_d.alu_op = {f7[5], f3};
                end else begin
                    ctl_d.alu_op = {1'b0, f3};
                end
            end
            7'b0000011: begin
                ctl_d.write = 1'b1;
                ctl_d.load  = 1'b1;
                ctl_d.b_sel = 2'b01;
                bad = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                        f3 == 3'b100 || f3 == 3'b101);
            end
            7'b0100011: begin
                ctl_d.store   = 1'b1;
                ctl_d.b_sel   = 2'b01;
                ctl_d.imm_sel = 3'b001;
                bad = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
            end
            7'b1100011: begin
                ctl_d.branch  = 1'b1;
                ctl_d.imm_sel = 3'b010;
                ctl_d.alu_op  = 4'b1000;
                ctl_d.npc_sel = 2'b01;
                bad = (f3 == 3'b010 || f3 == 3'b011);
            end
            7'b1100111: begin
                ctl_d.write   = 1'b1;
                ctl_d.a_sel   = 2'b01;
                ctl_d.b_sel   = 2'b10;
                ctl_d.npc_sel = 2'b10;
                bad = (f3 != 3'b000);
            end
            7'b1101111: begin
                ctl_d.write   = 1'b1;
                ctl_d.a_sel   = 2'b01;
                ctl_d.b_sel   = 2'b10;
                ctl_d.imm_sel = 3'b100;
                ctl_d.npc_sel = 2'b11;
            end
            7'b0110111: begin
                ctl_d.write   = 1'b1;
                ctl_d.a_sel   = 2'b10;
                ctl_d.b_sel   = 2'b01;
                ctl_d.imm_sel = 3'b011;
            end
            7'b0010111: begin
                ctl_d.write   = 1'b1;
                ctl_d.a_sel   = 2'b01;
                ctl_d.b_sel   = 2'b01;
                ctl_d.imm_sel = 3'b011;
            end
            default: bad = 1'b1;
        endcase
        // Illegal words must not cause side effects downstream: clear every control.
        if (bad) begin
            ctl_d         = '0;
            ctl_d.illegal = 1'b1;
            is_md_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            ctl_q       <= '0;
            pc_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            f3_q        <= '0;
            md_start_q  <= 1'b0;
            md_abort_q  <= 1'b0;
            md_op_q     <= '0;
            cnt_q       <= '0;
        end else begin
            md_start_q <= 1'b0;
            md_abort_q <= 1'b0;

            // A flush in the same cycle cancels the handshake, so it is not counted.
            if (out_valid_q && out_ready && !flush && ctl_q.illegal && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state_q == RUN) begin
                if (flush) begin
                    out_valid_q <= 1'b0;
                end else if (accept) begin
                    ctl_q <= ctl_d;
                    pc_q  <= in_pc;
                    rd_q  <= in_instr[11:7];
                    rs1_q <= in_instr[19:15];
                    rs2_q <= in_instr[24:20];
                    f3_q  <= f3;
                    if (is_md_d) begin
                        state_q     <= MD_WAIT;
                        md_start_q  <= 1'b1;
                        md_op_q     <= f3;
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end else begin
                if (flush) begin
                    md_abort_q  <= 1'b1;
                    state_q     <= RUN;
                    out_valid_q <= 1'b0;
                end else if (md_done && !md_start_q) begin
                    // md_done coincident with md_start belongs to an earlier op; ignore it.
                    out_valid_q <= 1'b1;
                    state_q     <= RUN;
                end
            end
        end
    end

    assign out_valid               = out_valid_q;
    assign out_pc                  = pc_q;
    assign out_rd                  = rd_q;
    assign out_rs1                 = rs1_q;
    assign out_rs2                 = rs2_q;
    assign out_func_3              = f3_q;
    assign write                   = ctl_q.write;
    assign store                   = ctl_q.store;
    assign load                    = ctl_q.load;
    assign branch                  = ctl_q.branch;
    assign alu_operand_a_selector  = ctl_q.a_sel;
    assign alu_operand_b_selector  = ctl_q.b_sel;
    assign immediate_selector      = ctl_q.imm_sel;
    assign next_pc_selector        = ctl_q.npc_sel;
    assign alu_operations_selector = ctl_q.alu_op;
    assign out_illegal             = ctl_q.illegal;
    assign md_start                = md_start_q;
    assign md_abort                = md_abort_q;
    assign md_op                   = md_op_q;
    assign illegal_count           = cnt_q;

endmodule
